tx_upmix: RTL and testbench
===========================

// Module: tx_upmix
// PURPOSE
//  Transmit up-converter: the transmit-side counterpart of the receive mixer. Accepts baseband I/Q
//  over a valid/ready handshake and holds each sample for INTERP clocks. Mixes the held sample
//  against an internal NCO: dac = I*cos - Q*sin. Produces a rounded, saturated two's-complement
//  sample for the TX DAC every clock. Sits between the TX baseband FIFO/interpolator and the DAC pins.
// PARAMETERS
//  IQ_W     16  width of signed I and Q input samples
//  DAC_W    12  width of signed DAC output
//  LUT_AW   10  quarter-wave sine ROM address bits (2^LUT_AW+1 entries, 18-bit signed, peak 131071)
//  INTERP    8  clocks each accepted I/Q sample is held (>=1)
// PORTS
//  clk          in   1       sample clock; all logic on rising edge
//  rst          in   1       asynchronous, active-low reset
//  tx_en        in   1       transmit enable
//  phase_inc    in   32      NCO tuning word, sampled every clock
//  iq_i         in   IQ_W    signed I sample
//  iq_q         in   IQ_W    signed Q sample
//  iq_valid     in   1       I/Q sample present
//  iq_ready     out  1       block accepts I/Q this clock
//  dac_data     out  DAC_W   signed mixed output
//  tx_active    out  1       high in PRIME or RUN
//  underrun     out  1       sticky: sample slot missed while in RUN
//  underrun_clr in   1       clears underrun
// BEHAVIOUR
//  Reset: all outputs 0, phase accumulator 0, hold register 0, state IDLE, slot counter 0.
//  NCO: 32-bit accumulator, phase <= phase + phase_inc every clock in every state. The phase is
//   continuous across tx_en toggles. The top 2 bits select the quadrant. The next LUT_AW bits
//   address the ROM; cos uses the mirrored address; signs come from the quadrant.
//  FSM:
//   IDLE  iq_ready=0, hold=0. tx_en=1 -> PRIME.
//   PRIME iq_ready=1. On iq_valid: load hold, cnt<=INTERP-1, -> RUN.
//   RUN   iq_ready=(cnt==0). cnt counts down and wraps to INTERP-1.
//         At cnt==0 with iq_valid: load hold.
//         At cnt==0 without iq_valid: load hold with 0 and set underrun.
//         INTERP=1 gives iq_ready=1 every RUN clock.
//   Any state: tx_en=0 -> IDLE next clock, and hold cleared the same edge.
//   tx_en=0 takes priority over a handshake in that clock; that sample is not accepted.
//  Arithmetic: products are full precision, IQ_W+18 bits. The sum is 1 bit wider.
//   Shift right by IQ_W+17-DAC_W with round-half-up.
//   Saturate to +/-(2^(DAC_W-1)-1); -2^(DAC_W-1) is never emitted.
//  Latency: a sample accepted at edge k first reaches dac_data at edge k+5. The NCO is
//   delay-matched so the phase and I/Q of one clock combine in the same output.
//  After tx_en falls, dac_data reaches 0 within 5 clocks. tx_active drops on the IDLE edge.
//  underrun_clr and a new underrun in the same clock: set wins.
//  Reset asserted mid-operation: immediate return to reset values, no flush.
// CONFIGURATION
//  TX_UPMIX_CW_EN defined: adds inputs cw_key (1) and cw_amp (IQ_W).
//   When cw_key=1 and the state is PRIME or RUN, the mixer uses I=cw_amp, Q=0 and ignores the hold register.
//   In PRIME the FSM goes to RUN without a handshake. iq_ready stays low, and underrun is not set.
//   Latency is unchanged.
//  TX_UPMIX_CW_EN not defined: those ports are absent and the datapath always uses the hold register.
// TESTING
//  1 Reset low with random inputs -> dac_data=0, iq_ready=0, tx_active=0, underrun=0.
//  2 phase_inc=0, tx_en=1, I=0x4000, Q=0 held valid -> iq_ready pulses once per 8 clocks.
//    dac_data=1024 (+/-1) from 5 clocks after the first accept.
//  3 phase_inc=0x40000000, I=0x4000, Q=0 -> dac_data cycles 1024,0,-1024,0 (+/-1).
//    With I=0, Q=0x4000 the sequence is 0,-1024,0,1024.
//  4 I=0x7FFF, Q=-0x8000, phase 45deg (phase_inc=0x20000000, check the matching step) -> dac_data=+2047.
//    This confirms saturation and that -2048 never appears.
//  5 In RUN, drop iq_valid for one slot -> underrun=1 and dac_data=0 for 8 clocks.
//    underrun_clr together with a second miss -> underrun stays 1.
//  6 Deassert tx_en mid-slot -> iq_ready=0 next clock and dac_data=0 within 5 clocks.
//    Phase continuity is checked on re-enable.
//    With TX_UPMIX_CW_EN: cw_key=1, cw_amp=0x4000, phase_inc=0 -> dac_data=1024 and iq_ready=0.

Source files
------------

// File: rtl/tx_upmix.sv
// tx_upmix: transmit up-converter between the TX baseband FIFO and the DAC.
// Accepts I/Q over valid/ready, holds each sample for INTERP clocks, and mixes
// it against an internal NCO (dac = I*cos - Q*sin). The result is rounded
// half-up and saturated symmetrically to +/-(2^(DAC_W-1)-1).
// Optional CW keying is enabled by defining TX_UPMIX_CW_EN (adds cw_key, cw_amp).
module tx_upmix #(
    parameter int IQ_W   = 16,
    parameter int DAC_W  = 12,
    parameter int LUT_AW = 10,
    parameter int INTERP = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_en,
    input  logic [31:0]             phase_inc,
    input  logic signed [IQ_W-1:0]  iq_i,
    input  logic signed [IQ_W-1:0]  iq_q,
    input  logic                    iq_valid,
    output logic                    iq_ready,
    output logic signed [DAC_W-1:0] dac_data,
    output logic                    tx_active,
    output logic                    underrun,
    input  logic                    underrun_clr
`ifdef TX_UPMIX_CW_EN
    ,
    input  logic                    cw_key,
    input  logic signed [IQ_W-1:0]  cw_amp
`endif
);

    localparam int LUT_W  = 18;
    localparam int ROM_N  = 2 ** LUT_AW;
    localparam int CNT_W  = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int PROD_W = IQ_W + LUT_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int SH     = IQ_W + 17 - DAC_W;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(INTERP - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(2 ** (DAC_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO   = -SAT_HI;
    localparam logic signed [DAC_W-1:0] OUT_HI   = DAC_W'(2 ** (DAC_W - 1) - 1);
    localparam logic signed [DAC_W-1:0] OUT_LO   = -OUT_HI;
    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) <<< (SH - 1);

    // Quarter-wave sine entry, peak 131071, computed with integer Taylor series
    // in Q28 so the table is built at elaboration without real arithmetic.
    function automatic int sin_entry(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(idx) * 64'sd421657428) >>> LUT_AW;
        x2   = (x * x) >>> 28;
        term = x;
        acc  = x;
        for (int unsigned k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        acc = (acc * 131071 + (64'sd1 <<< 27)) >>> 28;
        if (acc > 131071) acc = 131071;
        if (acc < 0) acc = 0;
        return int'(acc);
    endfunction

    logic [LUT_W-1:0] rom [0:ROM_N];

    for (genvar g = 0; g <= ROM_N; g++) begin : g_rom
        localparam int VAL = sin_entry(g);
        assign rom[g] = LUT_W'(VAL);
    end

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   ready_q;
    logic                   cw_on;
    logic                   take;
    logic signed [IQ_W-1:0] hold_i;
    logic signed [IQ_W-1:0] hold_q;
    logic signed [IQ_W-1:0] mix_i;
    logic signed [IQ_W-1:0] mix_q;

    logic [31:0]       phase;
    logic [1:0]        quad;
    logic [LUT_AW:0]   addr_fwd;
    logic [LUT_AW:0]   addr_rev;
    logic [LUT_AW:0]   sin_idx;
    logic [LUT_AW:0]   cos_idx;

    logic signed [IQ_W-1:0]   s1_i;
    logic signed [IQ_W-1:0]   s1_q;
    logic signed [LUT_W-1:0]  s1_sin_mag;
    logic signed [LUT_W-1:0]  s1_cos_mag;
    logic                     s1_sin_neg;
    logic                     s1_cos_neg;
    logic signed [IQ_W-1:0]   s2_i;
    logic signed [IQ_W-1:0]   s2_q;
    logic signed [LUT_W-1:0]  s2_sin;
    logic signed [LUT_W-1:0]  s2_cos;
    logic signed [PROD_W-1:0] p_ic;
    logic signed [PROD_W-1:0] p_qs;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  rnd;

`ifdef TX_UPMIX_CW_EN
    assign cw_on    = cw_key;
    assign iq_ready = ready_q & ~cw_key;
`else
    assign cw_on    = 1'b0;
    assign iq_ready = ready_q;
`endif

    assign take = iq_valid & iq_ready;

    // Operand select: CW keying overrides the hold register outside IDLE
    always_comb begin
        mix_i = hold_i;
        mix_q = hold_q;
        if (cw_on && (state != IDLE)) begin
            mix_i = cw_amp_sel();
            mix_q = '0;
        end
    end

    function automatic logic signed [IQ_W-1:0] cw_amp_sel();
`ifdef TX_UPMIX_CW_EN
        return cw_amp;
`else
        return '0;
`endif
    endfunction

    // Handshake FSM, hold register, slot counter and sticky underrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b0;
            tx_active <= 1'b0;
            underrun  <= 1'b0;
            hold_i    <= '0;
            hold_q    <= '0;
        end else begin
            // A new underrun later in this block overrides the clear.
            if (underrun_clr) underrun <= 1'b0;
            if (!tx_en) begin
                state     <= IDLE;
                cnt       <= '0;
                ready_q   <= 1'b0;
                tx_active <= 1'b0;
                hold_i    <= '0;
                hold_q    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= PRIME;
                        ready_q   <= 1'b1;
                        tx_active <= 1'b1;
                    end
                    PRIME: begin
                        if (take || cw_on) begin
                            if (take) begin
                                hold_i <= iq_i;
                                hold_q <= iq_q;
                            end
                            state   <= RUN;
                            cnt     <= CNT_LAST;
                            ready_q <= (INTERP == 1);
                        end
                    end
                    RUN: begin
                        if (cnt == '0) begin
                            cnt     <= CNT_LAST;
                            ready_q <= (INTERP == 1);
                            if (take) begin
                                hold_i <= iq_i;
                                hold_q <= iq_q;
                            end else if (!cw_on) begin
                                hold_i   <= '0;
                                hold_q   <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            cnt     <= cnt - 1'b1;
                            ready_q <= (cnt == CNT_W'(1));
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NCO phase accumulator, free-running in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase <= '0;
        else      phase <= phase + phase_inc;
    end

    // Quadrant folding: cos reads the mirrored address, signs from the quadrant
    always_comb begin
        quad     = phase[31:30];
        addr_fwd = {1'b0, phase[29 -: LUT_AW]};
        addr_rev = (LUT_AW + 1)'(ROM_N) - addr_fwd;
        sin_idx  = quad[0] ? addr_rev : addr_fwd;
        cos_idx  = quad[0] ? addr_fwd : addr_rev;
    end

    // Round half-up then arithmetic shift down to the DAC scale
    always_comb begin
        rnd = (sum + RND_HALF) >>> SH;
    end

    // Five-stage mixer; the NCO lookup enters with the operand of the same
    // clock so phase and sample stay aligned through every stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_i       <= '0;
            s1_q       <= '0;
            s1_sin_mag <= '0;
            s1_cos_mag <= '0;
            s1_sin_neg <= 1'b0;
            s1_cos_neg <= 1'b0;
            s2_i       <= '0;
            s2_q       <= '0;
            s2_sin     <= '0;
            s2_cos     <= '0;
            p_ic       <= '0;
            p_qs       <= '0;
            sum        <= '0;
            dac_data   <= '0;
        end else begin
            s1_i       <= mix_i;
            s1_q       <= mix_q;
            s1_sin_mag <= rom[sin_idx];
            s1_cos_mag <= rom[cos_idx];
            s1_sin_neg <= quad[1];
            s1_cos_neg <= quad[1] ^ quad[0];
            s2_i       <= s1_i;
            s2_q       <= s1_q;
            s2_sin     <= s1_sin_neg ? -s1_sin_mag : s1_sin_mag;
            s2_cos     <= s1_cos_neg ? -s1_cos_mag : s1_cos_mag;
            p_ic       <= PROD_W'(s2_i) * PROD_W'(s2_cos);
            p_qs       <= PROD_W'(s2_q) * PROD_W'(s2_sin);
            sum        <= SUM_W'(p_ic) - SUM_W'(p_qs);
            if (rnd > SAT_HI)      dac_data <= OUT_HI;
            else if (rnd < SAT_LO) dac_data <= OUT_LO;
            else                   dac_data <= rnd[DAC_W-1:0];
        end
    end

endmodule

// File: tb/tb_tx_upmix.sv
// Directed bench for tx_upmix: vector table for the mixer arithmetic plus
// hand-written sequences for handshake timing, underrun, enable and reset.
module tb_tx_upmix;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               tx_en;
    logic [31:0]        phase_inc;
    logic signed [15:0] iq_i;
    logic signed [15:0] iq_q;
    logic               iq_valid;
    logic               iq_ready;
    logic signed [11:0] dac_data;
    logic               tx_active;
    logic               underrun;
    logic               underrun_clr;
`ifdef TX_UPMIX_CW_EN
    logic               cw_key;
    logic signed [15:0] cw_amp;
`endif

    tx_upmix #(
        .IQ_W  (16),
        .DAC_W (12),
        .LUT_AW(10),
        .INTERP(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .phase_inc   (phase_inc),
        .iq_i        (iq_i),
        .iq_q        (iq_q),
        .iq_valid    (iq_valid),
        .iq_ready    (iq_ready),
        .dac_data    (dac_data),
        .tx_active   (tx_active),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
`ifdef TX_UPMIX_CW_EN
        ,
        .cw_key      (cw_key),
        .cw_amp      (cw_amp)
`endif
    );

    typedef struct {
        logic [31:0] pinc;
        int          i;
        int          q;
        int          step;
        int          expv;
        int          tol;
    } vec_t;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   quad_tbl [4];

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int expv, input int tol);
        checks++;
        if (act > expv + tol || act < expv - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cyc %0d", name, act, expv, tol, cyc);
        end
    endtask

    task automatic idle_inputs();
        tx_en        = 1'b0;
        phase_inc    = '0;
        iq_i         = '0;
        iq_q         = '0;
        iq_valid     = 1'b0;
        underrun_clr = 1'b0;
`ifdef TX_UPMIX_CW_EN
        cw_key       = 1'b0;
        cw_amp       = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        do_reset();
        phase_inc = v.pinc;
        iq_i      = 16'(v.i);
        iq_q      = 16'(v.q);
        iq_valid  = 1'b1;
        tx_en     = 1'b1;
        repeat (v.step) tick();
        check($sformatf("vec%0d", k), int'(dac_data), v.expv, v.tol);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // {phase_inc, I, Q, edge after reset release, expected dac, tolerance}
        vecs[0]  = '{32'h0000_0000,  16384,      0,  7,  1024, 1};
        vecs[1]  = '{32'h0000_0000,      0,  16384,  7,     0, 1};
        vecs[2]  = '{32'h0000_0000, -16384,      0,  7, -1024, 1};
        vecs[3]  = '{32'h4000_0000,  16384,      0,  7, -1024, 1};
        vecs[4]  = '{32'h4000_0000,  16384,      0,  8,     0, 1};
        vecs[5]  = '{32'h4000_0000,  16384,      0,  9,  1024, 1};
        vecs[6]  = '{32'h4000_0000,  16384,      0, 10,     0, 1};
        vecs[7]  = '{32'h4000_0000,      0,  16384,  7,     0, 1};
        vecs[8]  = '{32'h4000_0000,      0,  16384,  8,  1024, 1};
        vecs[9]  = '{32'h4000_0000,      0,  16384, 10, -1024, 1};
        vecs[10] = '{32'h2000_0000,  32767, -32768, 14,  2047, 0};
        vecs[11] = '{32'h2000_0000,  32767, -32768, 10, -2047, 0};
        vecs[12] = '{32'h0000_0000,      8,      0,  7,     0, 0};
        vecs[13] = '{32'h0000_0000,      9,      0,  7,     1, 0};
        vecs[14] = '{32'h0000_0000,     -9,      0,  7,    -1, 0};
        vecs[15] = '{32'h4000_0000,      0, -16384, 10,  1024, 1};
        quad_tbl = '{1024, 0, -1024, 0};

        // Reset held with random inputs
        rst = 1'b0;
        idle_inputs();
        for (int n = 0; n < 6; n++) begin
            tx_en        = 1'($urandom);
            phase_inc    = $urandom;
            iq_i         = 16'($urandom);
            iq_q         = 16'($urandom);
            iq_valid     = 1'($urandom);
            underrun_clr = 1'($urandom);
            tick();
        end
        check("rst_dac", int'(dac_data), 0, 0);
        check("rst_ready", int'(iq_ready), 0, 0);
        check("rst_active", int'(tx_active), 0, 0);
        check("rst_underrun", int'(underrun), 0, 0);

        // Mixer arithmetic table
        for (int k = 0; k < 16; k++) run_vec(vecs[k], k);

        // Handshake cadence and first-sample latency
        do_reset();
        iq_i     = 16'sd16384;
        iq_valid = 1'b1;
        tx_en    = 1'b1;
        tick();
        check("prime_ready", int'(iq_ready), 1, 0);
        check("prime_active", int'(tx_active), 1, 0);
        tick();
        check("accept_ready", int'(iq_ready), 0, 0);
        for (int n = 3; n <= 33; n++) begin
            tick();
            check("ready_slot", int'(iq_ready), (cyc % 8 == 1) ? 1 : 0, 0);
            if (cyc == 6) check("latency_pre", int'(dac_data), 0, 0);
            if (cyc == 7) check("latency_first", int'(dac_data), 1024, 1);
        end

        // Underrun: one missed slot, then clear racing a second miss
        do_reset();
        iq_i     = 16'sd16384;
        iq_valid = 1'b1;
        tx_en    = 1'b1;
        while (cyc < 9) tick();
        check("slot_ready", int'(iq_ready), 1, 0);
        iq_valid = 1'b0;
        tick();
        check("underrun_set", int'(underrun), 1, 0);
        iq_valid = 1'b1;
        for (int n = 11; n <= 23; n++) begin
            tick();
            check("underrun_dac", int'(dac_data), (cyc >= 15 && cyc <= 22) ? 0 : 1024,
                  (cyc >= 15 && cyc <= 22) ? 0 : 1);
        end
        check("underrun_sticky", int'(underrun), 1, 0);
        while (cyc < 25) tick();
        iq_valid     = 1'b0;
        underrun_clr = 1'b1;
        tick();
        check("clr_vs_set", int'(underrun), 1, 0);
        iq_valid = 1'b1;
        tick();
        check("clr_alone", int'(underrun), 0, 0);
        underrun_clr = 1'b0;

        // Enable drop mid-slot, then phase continuity on re-enable
        do_reset();
        phase_inc = 32'h4000_0000;
        iq_i      = 16'sd16384;
        iq_valid  = 1'b1;
        tx_en     = 1'b1;
        while (cyc < 11) tick();
        check("pre_drop_dac", int'(dac_data), quad_tbl[(cyc - 5) % 4], 1);
        tick();
        tx_en = 1'b0;
        tick();
        check("drop_ready", int'(iq_ready), 0, 0);
        check("drop_active", int'(tx_active), 0, 0);
        while (cyc < 18) tick();
        check("drop_dac_zero", int'(dac_data), 0, 0);
        tick();
        tx_en = 1'b1;
        tick();
        check("reen_ready", int'(iq_ready), 1, 0);
        while (cyc < 25) tick();
        for (int n = 26; n <= 29; n++) begin
            tick();
            check("phase_cont", int'(dac_data), quad_tbl[(cyc - 5) % 4], 1);
        end

        // Asynchronous reset mid-operation
        rst = 1'b0;
        #1;
        check("async_rst_dac", int'(dac_data), 0, 0);
        check("async_rst_active", int'(tx_active), 0, 0);
        check("async_rst_ready", int'(iq_ready), 0, 0);

`ifdef TX_UPMIX_CW_EN
        // CW keying: fixed amplitude, no handshake, no underrun
        do_reset();
        cw_key   = 1'b1;
        cw_amp   = 16'sd16384;
        iq_valid = 1'b1;
        tx_en    = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("cw_ready", int'(iq_ready), 0, 0);
        end
        check("cw_dac", int'(dac_data), 1024, 1);
        check("cw_underrun", int'(underrun), 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
